// File: rtl/turbo_deinterleaver.sv
// QPP turbo de-interleaver: writes one K-symbol block at permuted addresses, reads it back in order.
// Optional `dout_last` port is enabled by defining TURBO_DEINT_LAST_EN.
module turbo_deinterleaver #(
   parameter int unsigned K_LOG2 = 10,
   parameter int unsigned DW     = 8
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          id_enable,
   input  logic [5:0]    link_id,
   input  logic          din_valid,
   input  logic [DW-1:0] din,
   output logic          din_ready,
   output logic          dout_valid,
   output logic [DW-1:0] dout,
   input  logic          dout_ready,
`ifdef TURBO_DEINT_LAST_EN
   output logic          dout_last,
`endif
   output logic          busy,
   output logic          done
);

   localparam int unsigned K = 1 << K_LOG2;

   typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
   typedef logic [K_LOG2-1:0] addr_t;

   state_e        state_q, state_d;
   addr_t         pi_q, pi_d;
   addr_t         g_q, g_d;
   addr_t         step_q, step_d;
   addr_t         wr_cnt_q, wr_cnt_d;
   addr_t         rd_ptr_q, rd_ptr_d;
   logic          dout_valid_q, dout_valid_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          last_q, last_d;
   logic          done_q, done_d;

   logic [DW-1:0] mem_q [K];
   logic          mem_we;
   addr_t         f1, f2;

   // Coefficients are formed from the live link_id; they only matter on the strobe cycle.
   assign f1 = addr_t'({link_id, 1'b1});
   assign f2 = addr_t'({link_id, 1'b0});

   always_comb begin
      state_d      = state_q;
      pi_d         = pi_q;
      g_d          = g_q;
      step_d       = step_q;
      wr_cnt_d     = wr_cnt_q;
      rd_ptr_d     = rd_ptr_q;
      dout_valid_d = dout_valid_q;
      dout_d       = dout_q;
      last_d       = last_q;
      done_d       = 1'b0;
      mem_we       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (id_enable) begin
               pi_d     = '0;
               g_d      = f1 + f2;
               step_d   = f2 + f2;
               wr_cnt_d = '0;
               rd_ptr_d = '0;
               state_d  = StWrite;
            end
         end
         StWrite: begin
            if (din_valid) begin
               mem_we   = 1'b1;
               pi_d     = pi_q + g_q;
               g_d      = g_q + step_q;
               wr_cnt_d = wr_cnt_q + addr_t'(1);
               if (wr_cnt_q == '1) begin
                  rd_ptr_d = '0;
                  state_d  = StRead;
               end
            end
         end
         StRead: begin
            // last_q marks that the final symbol sits in the output register.
            if (dout_valid_q && dout_ready && last_q) begin
               done_d       = 1'b1;
               dout_valid_d = 1'b0;
               last_d       = 1'b0;
               state_d      = StIdle;
            end else if (!dout_valid_q || dout_ready) begin
               dout_d       = mem_q[rd_ptr_q];
               dout_valid_d = 1'b1;
               last_d       = (rd_ptr_q == '1);
               rd_ptr_d     = rd_ptr_q + addr_t'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= StIdle;
         pi_q         <= '0;
         g_q          <= '0;
         step_q       <= '0;
         wr_cnt_q     <= '0;
         rd_ptr_q     <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pi_q         <= pi_d;
         g_q          <= g_d;
         step_q       <= step_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         dout_valid_q <= dout_valid_d;
         dout_q       <= dout_d;
         last_q       <= last_d;
         done_q       <= done_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (n_rst && mem_we) begin
         mem_q[pi_q] <= din;
      end
   end

   assign din_ready  = (state_q == StWrite);
   assign busy       = (state_q != StIdle);
   assign dout_valid = dout_valid_q;
   assign dout       = dout_q;
   assign done       = done_q;
`ifdef TURBO_DEINT_LAST_EN
   assign dout_last  = last_q;
`endif

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Scoreboard bench for turbo_deinterleaver: a QPP reference model feeds an expected-output queue.
// Also exercises dout_last when built with TURBO_DEINT_LAST_EN.
module tb_turbo_deinterleaver;

   localparam int K_LOG2 = 10;
   localparam int DW     = 8;
   localparam int K      = 1 << K_LOG2;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          id_enable;
   logic [5:0]    link_id;
   logic          din_valid;
   logic [DW-1:0] din;
   logic          din_ready;
   logic          dout_valid;
   logic [DW-1:0] dout;
   logic          dout_ready;
   logic          busy;
   logic          done;
`ifdef TURBO_DEINT_LAST_EN
   logic          dout_last;
`endif

   int            errors   = 0;
   int            checks   = 0;
   int            done_cnt = 0;
   int            out_idx  = 0;
   bit            bp       = 1'b0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got[K];

   turbo_deinterleaver #(.K_LOG2(K_LOG2), .DW(DW)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .id_enable  (id_enable),
      .link_id    (link_id),
      .din_valid  (din_valid),
      .din        (din),
      .din_ready  (din_ready),
      .dout_valid (dout_valid),
      .dout       (dout),
      .dout_ready (dout_ready),
`ifdef TURBO_DEINT_LAST_EN
      .dout_last  (dout_last),
`endif
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 dout_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every accepted output, checks stall stability.
   initial begin
      logic          stall_prev;
      logic [DW-1:0] dout_prev;
      logic [DW-1:0] e;
      stall_prev = 1'b0;
      dout_prev  = '0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            stall_prev = 1'b0;
            out_idx    = 0;
         end else begin
            if (stall_prev) begin
               chk("stall_valid_held", int'(dout_valid), 1);
               chk("stall_dout_held", int'(dout), int'(dout_prev));
            end
            if (dout_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", out_idx, -1);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("dout[%0d]", out_idx), int'(dout), int'(e));
               end
`ifdef TURBO_DEINT_LAST_EN
               chk($sformatf("dout_last[%0d]", out_idx), int'(dout_last), int'(out_idx == K - 1));
`endif
               if (out_idx < K) got[out_idx] = dout;
               out_idx++;
            end
            stall_prev = dout_valid && !dout_ready;
            dout_prev  = dout;
            if (done) begin
               done_cnt++;
               out_idx = 0;
            end
         end
      end
   end

   task automatic run_block(input logic [5:0] lid, input bit rnd_valid, input bit rnd_data,
                            input bit bad_strobe, input int abort_at);
      logic [DW-1:0] data[K];
      logic [DW-1:0] model[K];
      longint        f1, f2, p;
      int            i, cyc;
      logic          fire;
      f1 = 2 * longint'(lid) + 1;
      f2 = 2 * longint'(lid);
      for (int k = 0; k < K; k++) data[k] = rnd_data ? DW'($urandom) : DW'(k);
      for (int k = 0; k < K; k++) begin
         p = (f1 * k + f2 * k * k) % K;
         model[p] = data[k];
      end
      @(posedge clk);
      #1 id_enable = 1'b1;
      link_id = lid;
      @(posedge clk);
      #1 id_enable = 1'b0;
      link_id = 6'($urandom);
      chk("din_ready_after_strobe", int'(din_ready), 1);
      i   = 0;
      cyc = 0;
      while (i < K && cyc < 8 * K) begin
         if (abort_at != 0 && i == abort_at) begin
            din_valid = 1'b0;
            n_rst     = 1'b0;
            @(posedge clk);
            #1 n_rst = 1'b1;
            chk("abort_din_ready", int'(din_ready), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_dout_valid", int'(dout_valid), 0);
            return;
         end
         din_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         din       = data[i];
         if (bad_strobe && i == 100) begin
            id_enable = 1'b1;
            link_id   = 6'h3F;
         end else begin
            id_enable = 1'b0;
         end
         fire = din_valid && din_ready;
         @(posedge clk);
         #1 cyc++;
         if (fire) i++;
      end
      din_valid = 1'b0;
      id_enable = 1'b0;
      if (i < K) chk("write_timeout", i, K);
      else for (int k = 0; k < K; k++) exp_q.push_back(model[k]);
   endtask

   task automatic wait_done(input int expd);
      int cyc;
      cyc = 0;
      while (done_cnt < expd && cyc < 8 * K) begin
         @(posedge clk);
         cyc++;
      end
      chk("done_seen", done_cnt, expd);
      repeat (3) @(posedge clk);
      #1 chk("done_single_pulse", done_cnt, expd);
      chk("busy_after_done", int'(busy), 0);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic chk_qpp_points();
      chk("out[0]", int'(got[0]), 0);
      chk("out[81]", int'(got[81]), 1);
      chk("out[242]", int'(got[242]), 2);
      chk("out[483]", int'(got[483]), 3);
   endtask

   initial begin
      n_rst     = 1'b0;
      id_enable = 1'b1;
      link_id   = 6'h14;
      din_valid = 1'b1;
      din       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_din_ready", int'(din_ready), 0);
      chk("rst_dout_valid", int'(dout_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
`ifdef TURBO_DEINT_LAST_EN
      chk("rst_dout_last", int'(dout_last), 0);
`endif
      n_rst     = 1'b1;
      id_enable = 1'b0;
      din_valid = 1'b0;
      @(posedge clk);
      #1 chk("strobe_in_reset_ignored", int'(busy), 0);

      run_block(6'h14, 1'b0, 1'b0, 1'b0, 0);
      wait_done(1);
      chk_qpp_points();

      run_block(6'h00, 1'b0, 1'b1, 1'b0, 0);
      wait_done(2);

      bp = 1'b1;
      run_block(6'h14, 1'b1, 1'b0, 1'b1, 0);
      wait_done(3);
      chk_qpp_points();
      bp = 1'b0;

      run_block(6'h14, 1'b0, 1'b0, 1'b0, 500);
      run_block(6'h14, 1'b0, 1'b1, 1'b0, 0);
      wait_done(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
